uart_rx_sipo: RTL and testbench

//   UART receive deserializer: serial-in, parallel-out counterpart of the UART-Tx PISO.
//   - Samples RxIn using a 16x-baud SampleTick enable.
//   - Detects the start bit, then shifts in 7/8 data bits LSB first, the optional parity bit and 1/2 stop bits.
//   - Presents the byte with error flags.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx_sipo.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx_sipo.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity selection codes,
// data length constants and small helpers used by the Rx deserializer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_t;

  localparam logic [1:0] PARITY_ODD  = 2'b01;
  localparam logic [1:0] PARITY_EVEN = 2'b10;

  localparam int DATA_BITS_7 = 7;
  localparam int DATA_BITS_8 = 8;

  // Shift register fills from the top, so a 7-bit frame sits in bits [7:1].
  function automatic logic [7:0] alignData(input logic [7:0] shiftVal, input logic eightBit);
    return eightBit ? shiftVal : {1'b0, shiftVal[7:1]};
  endfunction

  // Only the two explicit codes put a parity bit in the frame.
  function automatic logic parityEnabled(input logic [1:0] parityType);
    return (parityType == PARITY_ODD) || (parityType == PARITY_EVEN);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// RxIn synchronizer: SyncStages flops into the Clock domain, plus a
// registered copy of the synchronized line used for falling-edge detection.
module uart_rx_sync #(
  parameter int SyncStages = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic RxIn,
  output logic RxSync,
  output logic FallEdge
);

  logic [SyncStages-1:0] sync_q;
  logic                  prev_q;

  // Shift the raw line through the synchronizer; the line idles high,
  // so everything resets to 1 to avoid a false start after reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], RxIn};
      prev_q <= sync_q[SyncStages-1];
    end
  end

  assign RxSync   = sync_q[SyncStages-1];
  assign FallEdge = prev_q & ~sync_q[SyncStages-1];

endmodule

// File: rtl/uart_rx_sipo.sv
// UART receive deserializer. Oversamples the synchronized line with
// SampleTick, frames start/data/parity/stop bits and presents the byte with
// parity and framing error flags.
// Optional build macro: UART_RX_MAJORITY_EN (2-of-3 majority bit voting).
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int SyncStages = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       SampleTick,
  input  logic       RxIn,
  input  logic [1:0] ParityType,
  input  logic       StopBits,
  input  logic       DataLength,
  output logic [7:0] DataOut,
  output logic       DataValid,
  output logic       ParityError,
  output logic       FrameError,
  output logic       ActiveFlag,
  output logic       DoneFlag
);

  localparam int             CNT_W    = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] MID_TICK = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0]     LAST_BIT7 = 3'(DATA_BITS_7 - 1);
  localparam logic [2:0]     LAST_BIT8 = 3'(DATA_BITS_8 - 1);

  logic rxSync;
  logic fallEdge;
  logic bitVal;
  logic midTick;
  logic frameEnd;
  logic [2:0] lastBit;

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] tickCnt_q, tickCnt_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       parCfg_q, parCfg_d;
  logic             stopCfg_q, stopCfg_d;
  logic             lenCfg_q, lenCfg_d;
  logic             parAcc_q, parAcc_d;
  logic             frmAcc_q, frmAcc_d;
  logic             active_q, active_d;
  logic [7:0]       dataOut_q, dataOut_d;
  logic             dataValid_q, dataValid_d;
  logic             parErr_q, parErr_d;
  logic             frmErr_q, frmErr_d;

  uart_rx_sync #(
    .SyncStages(SyncStages)
  ) u_sync (
    .Clock   (Clock),
    .Reset   (Reset),
    .RxIn    (RxIn),
    .RxSync  (rxSync),
    .FallEdge(fallEdge)
  );

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] MAJ_TICK0 = CNT_W'(OVERSAMPLE / 2 - 3);
  localparam logic [CNT_W-1:0] MAJ_TICK1 = CNT_W'(OVERSAMPLE / 2 - 2);

  logic maj0_q, maj1_q;

  // Capture the two samples preceding the decision tick; the live sample at
  // the decision tick is the third vote, so bit timing does not move.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      maj0_q <= 1'b1;
      maj1_q <= 1'b1;
    end else if (SampleTick) begin
      if (tickCnt_q == MAJ_TICK0) maj0_q <= rxSync;
      if (tickCnt_q == MAJ_TICK1) maj1_q <= rxSync;
    end
  end

  assign bitVal = (maj0_q & maj1_q) | (maj0_q & rxSync) | (maj1_q & rxSync);
`else
  assign bitVal = rxSync;
`endif

  assign midTick = SampleTick && (tickCnt_q == MID_TICK);
  assign lastBit = lenCfg_q ? LAST_BIT8 : LAST_BIT7;

  // Next-state logic: frame sequencing, bit counting, error accumulation and
  // the single-cycle result update at frame end.
  always_comb begin
    state_d     = state_q;
    tickCnt_d   = tickCnt_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    parCfg_d    = parCfg_q;
    stopCfg_d   = stopCfg_q;
    lenCfg_d    = lenCfg_q;
    parAcc_d    = parAcc_q;
    frmAcc_d    = frmAcc_q;
    active_d    = active_q;
    dataOut_d   = dataOut_q;
    dataValid_d = 1'b0;
    parErr_d    = parErr_q;
    frmErr_d    = frmErr_q;
    frameEnd    = 1'b0;

    if (SampleTick) begin
      tickCnt_d = (tickCnt_q == TICK_MAX) ? '0 : tickCnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        parCfg_d  = ParityType;
        stopCfg_d = StopBits;
        lenCfg_d  = DataLength;
        if (fallEdge) begin
          state_d   = START;
          tickCnt_d = '0;
        end
      end
      START: begin
        if (midTick) begin
          if (!bitVal) begin
            state_d  = DATA;
            active_d = 1'b1;
            bitCnt_d = '0;
            parAcc_d = 1'b0;
            frmAcc_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (midTick) begin
          shift_d = {bitVal, shift_q[7:1]};
          if (bitCnt_q == lastBit) begin
            bitCnt_d = '0;
            state_d  = parityEnabled(parCfg_q) ? PARITY : STOP1;
          end else begin
            bitCnt_d = bitCnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (midTick) begin
          parAcc_d = bitVal ^ (^alignData(shift_q, lenCfg_q)) ^ (parCfg_q == PARITY_ODD);
          state_d  = STOP1;
        end
      end
      STOP1: begin
        if (midTick) begin
          frmAcc_d = ~bitVal;
          if (stopCfg_q) state_d = STOP2;
          else           frameEnd = 1'b1;
        end
      end
      STOP2: begin
        if (midTick) begin
          frmAcc_d = frmAcc_q | ~bitVal;
          frameEnd = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (frameEnd) begin
      state_d     = IDLE;
      active_d    = 1'b0;
      dataValid_d = 1'b1;
      dataOut_d   = alignData(shift_q, lenCfg_q);
      parErr_d    = parAcc_q;
      frmErr_d    = frmAcc_d;
    end
  end

  // State and datapath registers; reset abandons any partial frame.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      tickCnt_q   <= '0;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      parCfg_q    <= '0;
      stopCfg_q   <= 1'b0;
      lenCfg_q    <= 1'b0;
      parAcc_q    <= 1'b0;
      frmAcc_q    <= 1'b0;
      active_q    <= 1'b0;
      dataOut_q   <= '0;
      dataValid_q <= 1'b0;
      parErr_q    <= 1'b0;
      frmErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tickCnt_q   <= tickCnt_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      parCfg_q    <= parCfg_d;
      stopCfg_q   <= stopCfg_d;
      lenCfg_q    <= lenCfg_d;
      parAcc_q    <= parAcc_d;
      frmAcc_q    <= frmAcc_d;
      active_q    <= active_d;
      dataOut_q   <= dataOut_d;
      dataValid_q <= dataValid_d;
      parErr_q    <= parErr_d;
      frmErr_q    <= frmErr_d;
    end
  end

  assign DataOut     = dataOut_q;
  assign DataValid   = dataValid_q;
  assign ParityError = parErr_q;
  assign FrameError  = frmErr_q;
  assign ActiveFlag  = active_q;
  assign DoneFlag    = ~active_q;

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Testbench for uart_rx_sipo: serial frames are built from a bit-level model
// of the UART line format; the expected byte and flags go into a queue that a
// monitor drains on every DataValid pulse.
module tb_uart_rx_sipo;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       SampleTick;
  logic       RxIn;
  logic [1:0] ParityType;
  logic       StopBits;
  logic       DataLength;
  logic [7:0] DataOut;
  logic       DataValid;
  logic       ParityError;
  logic       FrameError;
  logic       ActiveFlag;
  logic       DoneFlag;

  exp_t expQ[$];
  int   checks       = 0;
  int   errors       = 0;
  int   dvCount      = 0;
  int   activeCycles = 0;
  int   framesPushed = 0;
  int   tickDiv      = 0;

  uart_rx_sipo #(
    .OVERSAMPLE(16),
    .SyncStages(2)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .SampleTick (SampleTick),
    .RxIn       (RxIn),
    .ParityType (ParityType),
    .StopBits   (StopBits),
    .DataLength (DataLength),
    .DataOut    (DataOut),
    .DataValid  (DataValid),
    .ParityError(ParityError),
    .FrameError (FrameError),
    .ActiveFlag (ActiveFlag),
    .DoneFlag   (DoneFlag)
  );

  // 100 MHz system clock.
  initial forever #5 Clock = ~Clock;

  // SampleTick: one-clock strobe every 4 clocks, so a nominal bit is 64 clocks.
  initial begin
    SampleTick = 1'b0;
    forever begin
      @(negedge Clock);
      tickDiv    = (tickDiv + 1) % 4;
      SampleTick = (tickDiv == 0);
    end
  end

  // Hard stop in case something wedges.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pops the oldest expectation on every DataValid pulse.
  task automatic monitorLoop();
    exp_t e;
    forever begin
      @(negedge Clock);
      if (ActiveFlag === 1'b1) activeCycles++;
      if (DataValid === 1'b1) begin
        dvCount++;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedValid actual=DataValid 1 required=no frame pending");
        end else begin
          e = expQ.pop_front();
          checkOutput("dataOut", DataOut, e.data);
          checkOutput("parityError", {7'b0, ParityError}, {7'b0, e.pe});
          checkOutput("frameError", {7'b0, FrameError}, {7'b0, e.fe});
        end
      end
    end
  endtask

  task automatic driveBit(input logic val, input int clocks);
    RxIn = val;
    repeat (clocks) @(negedge Clock);
  endtask

  // Sends one frame and queues what a correct receiver must report.
  task automatic applyStimulus(input logic [7:0] data, input logic len8, input logic [1:0] pty,
                               input logic twoStop, input logic flipPar, input logic stop1,
                               input logic stop2, input int bitClk, input int idleBits,
                               input logic scramble);
    exp_t e;
    int   nBits;
    int   ones;
    logic parEn;
    logic parBit;
    nBits  = len8 ? 8 : 7;
    e.data = len8 ? data : (data & 8'h7F);
    ones   = $countones(e.data);
    parEn  = (pty == 2'b01) || (pty == 2'b10);
    parBit = (pty == 2'b01) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    parBit = parBit ^ flipPar;
    e.pe   = parEn && flipPar;
    e.fe   = !stop1 || (twoStop && !stop2);
    ParityType = pty;
    StopBits   = twoStop;
    DataLength = len8;
    expQ.push_back(e);
    framesPushed++;
    driveBit(1'b0, bitClk);
    if (scramble) begin
      ParityType = 2'($urandom_range(0, 3));
      StopBits   = 1'($urandom_range(0, 1));
      DataLength = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < nBits; i++) begin
      if (i == 1) begin
        driveBit(data[i], bitClk / 2);
        checkOutput("activeMidFrame", {7'b0, ActiveFlag}, 8'h01);
        checkOutput("doneMidFrame", {7'b0, DoneFlag}, 8'h00);
        driveBit(data[i], bitClk - bitClk / 2);
      end else begin
        driveBit(data[i], bitClk);
      end
    end
    if (parEn) driveBit(parBit, bitClk);
    driveBit(stop1, bitClk);
    if (twoStop) driveBit(stop2, bitClk);
    driveBit(1'b1, idleBits * bitClk);
  endtask

  // Waits (bounded) for all queued frames to be reported, then checks idle flags.
  task automatic waitDrain(input string name);
    for (int c = 0; c < 400 && expQ.size() != 0; c++) @(negedge Clock);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_timeout actual=%0d pending required=0", name, expQ.size());
      expQ.delete();
    end
    checkOutput({name, "_done"}, {7'b0, DoneFlag}, 8'h01);
    checkOutput({name, "_active"}, {7'b0, ActiveFlag}, 8'h00);
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, "_dataOut"}, DataOut, 8'h00);
    checkOutput({name, "_valid"}, {7'b0, DataValid}, 8'h00);
    checkOutput({name, "_parErr"}, {7'b0, ParityError}, 8'h00);
    checkOutput({name, "_frmErr"}, {7'b0, FrameError}, 8'h00);
    checkOutput({name, "_active"}, {7'b0, ActiveFlag}, 8'h00);
    checkOutput({name, "_done"}, {7'b0, DoneFlag}, 8'h01);
  endtask

  initial begin
    int   dvBefore;
    int   actBefore;
    int   bitClk;
    int   idle;
    logic s1;
    logic s2;
    logic two;

    Reset      = 1'b1;
    RxIn       = 1'b1;
    ParityType = 2'b00;
    StopBits   = 1'b0;
    DataLength = 1'b1;
    fork
      monitorLoop();
    join_none
    repeat (5) @(negedge Clock);
    checkResetValues("resetHeld");
    Reset = 1'b0;
    repeat (5) @(negedge Clock);
    checkResetValues("afterReset");

    $display("[TB] 8N1 0xA5");
    applyStimulus(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 64, 1, 1'b0);
    waitDrain("frameA5");

    $display("[TB] 7E1 0x55 good and bad parity");
    applyStimulus(8'h55, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 64, 1, 1'b0);
    applyStimulus(8'h55, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 64, 1, 1'b0);
    waitDrain("parity7E");

    $display("[TB] 8N2 0x3C bad then clean stop");
    applyStimulus(8'h3C, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 64, 1, 1'b0);
    applyStimulus(8'h3C, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 64, 1, 1'b0);
    waitDrain("stop8N2");

    $display("[TB] idle glitch");
    dvBefore  = dvCount;
    actBefore = activeCycles;
    driveBit(1'b0, 16);
    driveBit(1'b1, 3 * 64);
    checkOutput("glitchActive", 8'(activeCycles - actBefore), 8'h00);
    checkOutput("glitchValid", 8'(dvCount - dvBefore), 8'h00);
    checkOutput("glitchDone", {7'b0, DoneFlag}, 8'h01);

    $display("[TB] reset during data bit 3");
    dvBefore   = dvCount;
    ParityType = 2'b00;
    StopBits   = 1'b0;
    DataLength = 1'b1;
    driveBit(1'b0, 64);
    driveBit(1'b1, 3 * 64 + 32);
    checkOutput("preResetActive", {7'b0, ActiveFlag}, 8'h01);
    Reset = 1'b1;
    #1;
    checkResetValues("midFrameReset");
    @(negedge Clock);
    driveBit(1'b1, 3);
    Reset = 1'b0;
    driveBit(1'b1, 8 * 64);
    checkOutput("resetNoValid", 8'(dvCount - dvBefore), 8'h00);
    applyStimulus(8'h12, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 64, 1, 1'b0);
    waitDrain("afterMidReset");

    $display("[TB] back-to-back skewed frames");
    applyStimulus(8'h01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 66, 0, 1'b0);
    applyStimulus(8'h80, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 62, 0, 1'b0);
    applyStimulus(8'hC3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 62, 1, 1'b0);
    waitDrain("backToBack");

    $display("[TB] randomized frames");
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 2))
        0:       bitClk = 62;
        1:       bitClk = 64;
        default: bitClk = 66;
      endcase
      two  = 1'($urandom_range(0, 1));
      s1   = ($urandom_range(0, 4) != 0);
      s2   = ($urandom_range(0, 4) != 0);
      idle = $urandom_range(0, 2);
      if (!s1 || (two && !s2)) idle = (idle == 0) ? 1 : idle;
      applyStimulus(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    two, ($urandom_range(0, 3) == 0), s1, s2, bitClk, idle, 1'b1);
    end
    driveBit(1'b1, 64);
    waitDrain("random");

    checkOutput("totalValid", 8'(dvCount), 8'(framesPushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
